load_store_unit: RTL and testbench

//  Initiator side of the word-wide data memory port: accepts core load/store requests of byte/half/word size,

---
 rtl/load_store_unit.sv | 201 ++++++++++++++++++++
 tb/tb_load_store_unit.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: word-wide data memory initiator, read-modify-write for sub-word stores, sign/zero-extended loads.
// Optional build macro LSU_MISALIGN_TRAP_EN: misaligned requests respond with resp_err instead of being aligned down.
module load_store_unit #(
    parameter int ADDR_WIDTH = 32'd32,
    parameter int DATA_WIDTH = 32'd32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_write
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    state_t                  state_r, state_nxt_s;
    logic                    we_r, uns_r;
    logic [1:0]              size_r, lane_r;
    logic [DATA_WIDTH-1:0]   wdata_r;
    logic [1:0]              lane_s;
    logic                    trap_s, accept_s;
    logic                    req_ready_r, resp_valid_r, resp_err_r, mem_write_r;
    logic [DATA_WIDTH-1:0]   resp_rdata_r, mem_wdata_r;
    logic [ADDR_WIDTH-1:0]   mem_addr_r;
    logic                    resp_err_nxt_s;
    logic [DATA_WIDTH-1:0]   resp_rdata_nxt_s, mem_wdata_nxt_s;
    logic [ADDR_WIDTH-1:0]   mem_addr_nxt_s;

    function automatic logic [DATA_WIDTH-1:0] merge_lanes(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_data,
        input logic [1:0]            size,
        input logic [1:0]            lane
    );
        logic [DATA_WIDTH-1:0] merged;
        merged = old_word;
        case (size)
            2'b00:   merged[{lane, 3'b000} +: 8]     = new_data[7:0];
            2'b01:   merged[{lane[1], 4'b0000} +: 16] = new_data[15:0];
            default: merged = new_data;
        endcase
        return merged;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] extend_load(
        input logic [DATA_WIDTH-1:0] word,
        input logic [1:0]            size,
        input logic [1:0]            lane,
        input logic                  is_unsigned
    );
        logic [7:0]            byte_v;
        logic [15:0]           half_v;
        logic [DATA_WIDTH-1:0] result;
        byte_v = word[{lane, 3'b000} +: 8];
        half_v = word[{lane[1], 4'b0000} +: 16];
        case (size)
            2'b00:   result = {{(DATA_WIDTH-8){byte_v[7] & ~is_unsigned}}, byte_v};
            2'b01:   result = {{(DATA_WIDTH-16){half_v[15] & ~is_unsigned}}, half_v};
            default: result = word;
        endcase
        return result;
    endfunction

`ifdef LSU_MISALIGN_TRAP_EN
    logic misalign_s;
    assign misalign_s = ((req_size == 2'b01) && req_addr[0]) ||
                        (req_size[1] && (req_addr[1:0] != 2'b00));
    assign trap_s     = misalign_s;
`else
    assign trap_s     = 1'b0;
`endif

    // Byte lane used by the request; offset bits a size cannot use are forced to zero
    always_comb begin
        lane_s = 2'b00;
        case (req_size)
            2'b00:   lane_s = req_addr[1:0];
            2'b01:   lane_s = {req_addr[1], 1'b0};
            default: lane_s = 2'b00;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next state and next values of the registered memory/response outputs
    always_comb begin
        state_nxt_s      = state_r;
        accept_s         = 1'b0;
        mem_addr_nxt_s   = mem_addr_r;
        mem_wdata_nxt_s  = mem_wdata_r;
        resp_rdata_nxt_s = resp_rdata_r;
        resp_err_nxt_s   = resp_err_r;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    accept_s       = 1'b1;
                    mem_addr_nxt_s = {req_addr[ADDR_WIDTH-1:2], 2'b00};
                    if (trap_s) begin
                        state_nxt_s      = ST_RESP;
                        resp_rdata_nxt_s = '0;
                        resp_err_nxt_s   = 1'b1;
                    end else if (req_we && req_size[1]) begin
                        state_nxt_s     = ST_WR;
                        mem_wdata_nxt_s = req_wdata;
                    end else begin
                        state_nxt_s = ST_RD;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RD: begin
                if (we_r) begin
                    state_nxt_s     = ST_WR;
                    mem_wdata_nxt_s = merge_lanes(mem_rdata, wdata_r, size_r, lane_r);
                end else begin
                    state_nxt_s      = ST_RESP;
                    resp_rdata_nxt_s = extend_load(mem_rdata, size_r, lane_r, uns_r);
                    resp_err_nxt_s   = 1'b0;
                end
            end
            ST_WR: begin
                state_nxt_s      = ST_RESP;
                resp_rdata_nxt_s = '0;
                resp_err_nxt_s   = 1'b0;
            end
            ST_RESP: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Request fields captured on the accept edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_r    <= 1'b0;
            uns_r   <= 1'b0;
            size_r  <= 2'b00;
            lane_r  <= 2'b00;
            wdata_r <= '0;
        end else if (accept_s) begin
            we_r    <= req_we;
            uns_r   <= req_unsigned;
            size_r  <= req_size;
            lane_r  <= lane_s;
            wdata_r <= req_wdata;
        end
    end

    // Registered outputs; strobes are decoded from the state being entered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_ready_r  <= 1'b1;
            resp_valid_r <= 1'b0;
            mem_write_r  <= 1'b0;
            resp_err_r   <= 1'b0;
            resp_rdata_r <= '0;
            mem_addr_r   <= '0;
            mem_wdata_r  <= '0;
        end else begin
            req_ready_r  <= (state_nxt_s == ST_IDLE);
            resp_valid_r <= (state_nxt_s == ST_RESP);
            mem_write_r  <= (state_nxt_s == ST_WR);
            resp_err_r   <= resp_err_nxt_s;
            resp_rdata_r <= resp_rdata_nxt_s;
            mem_addr_r   <= mem_addr_nxt_s;
            mem_wdata_r  <= mem_wdata_nxt_s;
        end
    end

    assign req_ready  = req_ready_r;
    assign resp_valid = resp_valid_r;
    assign resp_rdata = resp_rdata_r;
    assign resp_err   = resp_err_r;
    assign mem_addr   = mem_addr_r;
    assign mem_wdata  = mem_wdata_r;
    assign mem_write  = mem_write_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed scenarios, reset abort, then random traffic against a reference model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err, mem_write;
    logic [31:0] resp_rdata, mem_addr, mem_rdata, mem_wdata;

    load_store_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .mem_wdata(mem_wdata), .mem_write(mem_write)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Simple word memory with combinational read
    logic [31:0] mem [0:63];
    logic        mem_clear;
    assign mem_rdata = mem[mem_addr[7:2]];
    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
        end else if (mem_write) begin
            mem[mem_addr[7:2]] <= mem_wdata;
        end
    end

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          nwr;
        logic [31:0] waddr;
        logic [31:0] wdata;
        int          acc;
    } exp_t;

    exp_t        q[$];
    logic [31:0] ref_mem [0:63];
    int vectors = 0, miscompares = 0, checks = 0, wr_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: byte-addressed semantics with shifts and masks
    function automatic exp_t model(input logic we, input logic [1:0] size, input logic uns,
                                   input logic [7:0] addr, input logic [31:0] wdata);
        exp_t        e;
        int          sz, idx, shift;
        logic [31:0] word, mask, val;
        logic [7:0]  a;
        sz   = (size == 2'd3) ? 2 : int'(size);
        idx  = int'(addr[7:2]);
        word = ref_mem[idx];
        e.rdata = 32'h0; e.err = 1'b0; e.nwr = 0; e.lat = 2; e.acc = 0;
        e.waddr = {24'h0, addr[7:2], 2'b00}; e.wdata = 32'h0;
`ifdef LSU_MISALIGN_TRAP_EN
        if ((sz == 1 && addr[0]) || (sz == 2 && addr[1:0] != 2'b00)) begin
            e.err = 1'b1;
            e.lat = 1;
            return e;
        end
`endif
        a = addr;
        if (sz == 1) a[0] = 1'b0;
        if (sz == 2) a[1:0] = 2'b00;
        shift = 8 * int'(a[1:0]);
        mask  = (sz == 0) ? 32'h000000FF : (sz == 1) ? 32'h0000FFFF : 32'hFFFFFFFF;
        if (!we) begin
            val = (word >> shift) & mask;
            if (!uns && sz == 0 && val[7])  val = val | ~mask;
            if (!uns && sz == 1 && val[15]) val = val | ~mask;
            e.rdata = val;
        end else begin
            val = (word & ~(mask << shift)) | ((wdata & mask) << shift);
            e.wdata = val;
            e.nwr = 1;
            e.lat = (sz == 2) ? 2 : 3;
            ref_mem[idx] = val;
        end
        return e;
    endfunction

    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [7:0] addr, input logic [31:0] wdata);
        exp_t e;
        int   waited;
        e = model(we, size, uns, addr, wdata);
        @(negedge clk);
        req_we = we; req_size = size; req_unsigned = uns;
        req_addr = {24'h0, addr}; req_wdata = wdata; req_valid = 1'b1;
        waited = 0;
        while (!req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk("accept_timeout", {31'b0, req_ready}, 32'd1);
        e.acc = cyc;
        q.push_back(e);
        vectors++;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (q.size() != 0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("drain_timeout", q.size(), 32'd0);
    endtask

    // Monitor: compares every write strobe and response against the queue head
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (mem_write) begin
                    if (q.size() == 0) begin
                        chk("spurious_write", {31'b0, mem_write}, 32'd0);
                    end else begin
                        chk("write_addr", mem_addr, q[0].waddr);
                        chk("write_data", mem_wdata, q[0].wdata);
                        chk("write_cycle", cyc - q[0].acc, q[0].lat - 1);
                    end
                    wr_seen++;
                end
                if (resp_valid) begin
                    if (q.size() == 0) begin
                        chk("spurious_resp", {31'b0, resp_valid}, 32'd0);
                    end else begin
                        e = q.pop_front();
                        chk("resp_rdata", resp_rdata, e.rdata);
                        chk("resp_err", {31'b0, resp_err}, {31'b0, e.err});
                        chk("latency", cyc - e.acc, e.lat);
                        chk("write_count", wr_seen, e.nwr);
                    end
                    wr_seen = 0;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int w;
        rst = 1'b1; mem_clear = 1'b1; req_valid = 1'b0; req_we = 1'b0;
        req_size = 2'b00; req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        for (int i = 0; i < 64; i++) ref_mem[i] = 32'h0;
        #1;
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_resp_err", {31'b0, resp_err}, 32'd0);
        chk("rst_mem_write", {31'b0, mem_write}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        @(negedge clk); @(negedge clk);
        mem_clear = 1'b0; rst = 1'b0;

        issue(1'b1, 2'b10, 1'b0, 8'h08, 32'h88776655);
        issue(1'b0, 2'b00, 1'b0, 8'h0B, 32'h0);
        issue(1'b0, 2'b01, 1'b1, 8'h0A, 32'h0);
        issue(1'b0, 2'b01, 1'b0, 8'h08, 32'h0);
        issue(1'b1, 2'b00, 1'b0, 8'h09, 32'hFFFFFFAB);
        issue(1'b0, 2'b10, 1'b0, 8'h08, 32'h0);
        issue(1'b1, 2'b10, 1'b0, 8'h10, 32'h12345678);
        issue(1'b0, 2'b10, 1'b0, 8'h10, 32'h0);
        issue(1'b0, 2'b01, 1'b0, 8'h0B, 32'h0);
        issue(1'b0, 2'b11, 1'b1, 8'h0C, 32'h0);
        issue(1'b1, 2'b10, 1'b0, 8'h08, 32'h88776655);
        drain();

        // Reset while the read-modify-write store is in its write cycle
        @(negedge clk);
        req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h09; req_wdata = 32'h000000AB; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        w = 0;
        while (!mem_write && w < 5) begin
            @(posedge clk);
            #1 w++;
        end
        chk("abort_write_seen", {31'b0, mem_write}, 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("abort_write_drop", {31'b0, mem_write}, 32'd0);
        chk("abort_resp_valid", {31'b0, resp_valid}, 32'd0);
        @(posedge clk); @(posedge clk);
        @(negedge clk) rst = 1'b0;
        chk("abort_mem_word", mem[2], 32'h88776655);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_no_resp", {31'b0, resp_valid}, 32'd0);
        end
        issue(1'b0, 2'b10, 1'b0, 8'h08, 32'h0);
        drain();

        for (int n = 0; n < 300; n++) begin
            issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  8'($urandom_range(0, 255)), $urandom);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
